// File: rtl/umem_port_arbiter.sv
// Shares one unified memory port between fetch and load/store.
// Round-robin grant, registered command, registered response.
module umem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_inst,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic              mem_signed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              last_d;
    logic              cmd_valid;
    logic              cmd_inst;
    logic              cmd_we;
    logic [1:0]        cmd_size;
    logic              cmd_signed;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_err;
    logic              rsp_if;
    logic              rsp_d;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic              if_bad;
    logic              d_bad;

    // Grant: lone requester wins; on contention the one not granted last.
    always_comb begin
        if_gnt = rst & if_req & (~d_req | last_d);
        d_gnt  = rst & d_req & (~if_req | ~last_d);
    end

    // Alignment and size legality of the incoming requests.
    always_comb begin
        if_bad = |if_addr[1:0];
        case (d_size)
            2'b00:   d_bad = |d_addr[1:0];
            2'b01:   d_bad = d_addr[0];
            2'b10:   d_bad = 1'b0;
            default: d_bad = 1'b1;
        endcase
    end

    // Round-robin history; reset favours fetch on first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b1;
        end else if (if_gnt) begin
            last_d <= 1'b0;
        end else if (d_gnt) begin
            last_d <= 1'b1;
        end
    end

    // Command register: captures the granted request for the access stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid  <= 1'b0;
            cmd_inst   <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_size   <= 2'b00;
            cmd_signed <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_valid <= if_gnt | d_gnt;
            if (if_gnt) begin
                cmd_inst   <= 1'b1;
                cmd_we     <= 1'b0;
                cmd_size   <= 2'b00;
                cmd_signed <= 1'b0;
                cmd_addr   <= if_addr;
                cmd_wdata  <= '0;
                cmd_err    <= if_bad;
            end else if (d_gnt) begin
                cmd_inst   <= 1'b0;
                cmd_we     <= d_we;
                cmd_size   <= d_size;
                cmd_signed <= d_signed;
                cmd_addr   <= d_addr;
                cmd_wdata  <= d_wdata;
                cmd_err    <= d_bad;
            end
        end
    end

    // Access stage: drive the memory port; errors never touch memory.
    always_comb begin
        mem_inst   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = 2'b00;
        mem_signed = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (cmd_valid) begin
            mem_inst   = cmd_inst;
            mem_size   = cmd_size;
            mem_signed = cmd_signed;
            mem_addr   = cmd_inst ? {2'b00, cmd_addr[ADDR_W-1:2]} : cmd_addr;
            if (!cmd_err) begin
                mem_read  = ~cmd_we;
                mem_write = cmd_we;
                mem_wdata = cmd_we ? cmd_wdata : '0;
            end
        end
    end

    // Response register: read data for good loads, zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_if   <= 1'b0;
            rsp_d    <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_if   <= cmd_valid & cmd_inst;
            rsp_d    <= cmd_valid & ~cmd_inst;
            rsp_err  <= cmd_valid & cmd_err;
            rsp_data <= mem_read ? mem_rdata : '0;
        end
    end

    // Steer the response to the requester that issued it.
    always_comb begin
        if_rvalid = rsp_if;
        if_err    = rsp_if & rsp_err;
        if_rdata  = rsp_if ? rsp_data : '0;
        d_rvalid  = rsp_d;
        d_err     = rsp_d & rsp_err;
        d_rdata   = rsp_d ? rsp_data : '0;
    end

endmodule

// File: tb/tb_umem_port_arbiter.sv
// Directed bench for umem_port_arbiter with a small memory model.
// Vector table for single accesses plus hand-written sequences.
module tb_umem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_signed, d_gnt, d_rvalid, d_err;
    logic [1:0]  d_size;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_inst, mem_read, mem_write, mem_signed;
    logic [1:0]  mem_size;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] inst_mem [0:63];
    logic [7:0]  data_mem [0:255];

    always #5 clk = ~clk;

    umem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_inst(mem_inst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_signed(mem_signed), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: combinational read, size/sign handled by the memory.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = data_mem[mem_addr];
        b1 = data_mem[mem_addr + 8'd1];
        b2 = data_mem[mem_addr + 8'd2];
        b3 = data_mem[mem_addr + 8'd3];
        mem_rdata = '0;
        if (mem_inst) mem_rdata = inst_mem[mem_addr[5:0]];
        else begin
            case (mem_size)
                2'b00: mem_rdata = {b3, b2, b1, b0};
                2'b01: mem_rdata = {{16{mem_signed & b1[7]}}, b1, b0};
                2'b10: mem_rdata = {{24{mem_signed & b0[7]}}, b0};
                default: mem_rdata = '0;
            endcase
        end
    end

    // Memory write commits at the clock edge.
    always @(posedge clk) begin
        if (mem_write) begin
            data_mem[mem_addr] <= mem_wdata[7:0];
            if (mem_size != 2'b10) data_mem[mem_addr + 8'd1] <= mem_wdata[15:8];
            if (mem_size == 2'b00) begin
                data_mem[mem_addr + 8'd2] <= mem_wdata[23:16];
                data_mem[mem_addr + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        f;
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [7:0]  a;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        logic [7:0]  maddr;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt [11];

    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        @(negedge clk);
        if (v.f) begin
            if_req = 1'b1; if_addr = v.a;
        end else begin
            d_req = 1'b1; d_we = v.we; d_size = v.sz;
            d_signed = v.sg; d_addr = v.a; d_wdata = v.wd;
        end
        #1;
        chk({s, "_gnt"}, 32'(v.f ? if_gnt : d_gnt), 32'd1);
        chk({s, "_ogn"}, 32'(v.f ? d_gnt : if_gnt), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        chk({s, "_mrd"}, 32'(mem_read), 32'(v.rd));
        chk({s, "_mwr"}, 32'(mem_write), 32'(v.wr));
        chk({s, "_mins"}, 32'(mem_inst), 32'(v.f));
        if (v.rd | v.wr) chk({s, "_madr"}, 32'(mem_addr), 32'(v.maddr));
        if (v.wr) chk({s, "_mwd"}, mem_wdata, v.wd);
        @(posedge clk); #1;
        chk({s, "_rv"}, 32'(v.f ? if_rvalid : d_rvalid), 32'd1);
        chk({s, "_err"}, 32'(v.f ? if_err : d_err), 32'(v.err));
        chk({s, "_rdat"}, v.f ? if_rdata : d_rdata, v.rdata);
        @(posedge clk); #1;
        chk({s, "_rvq"}, 32'(if_rvalid | d_rvalid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) inst_mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) data_mem[i] = 8'h00;
        inst_mem[2] = 32'h00100093;
        data_mem[0] = 8'h78; data_mem[1] = 8'h56;
        data_mem[2] = 8'h34; data_mem[3] = 8'h80;

        //          f   we   sz     sg   a      wd            rd   wr   maddr  err  rdata
        vt[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 8'h08, 32'h0,        1'b1, 1'b0, 8'h02, 1'b0, 32'h00100093};
        vt[1]  = '{1'b0, 1'b0, 2'b01, 1'b1, 8'h02, 32'h0,        1'b1, 1'b0, 8'h02, 1'b0, 32'hFFFF8034};
        vt[2]  = '{1'b0, 1'b0, 2'b01, 1'b0, 8'h02, 32'h0,        1'b1, 1'b0, 8'h02, 1'b0, 32'h00008034};
        vt[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 8'h05, 32'h0,        1'b0, 1'b0, 8'h05, 1'b1, 32'h0};
        vt[4]  = '{1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 8'h09, 32'h0,        1'b0, 1'b0, 8'h02, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 1'b0, 2'b10, 1'b1, 8'h03, 32'h0,        1'b1, 1'b0, 8'h03, 1'b0, 32'hFFFFFF80};
        vt[7]  = '{1'b0, 1'b1, 2'b10, 1'b0, 8'h10, 32'h000000A5, 1'b0, 1'b1, 8'h10, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 1'b0, 2'b00, 1'b0, 8'h10, 32'h0,        1'b1, 1'b0, 8'h10, 1'b0, 32'h000000A5};
        vt[9]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h13, 32'h0000BEEF, 1'b0, 1'b0, 8'h13, 1'b1, 32'h0};
        vt[10] = '{1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 32'h80345678};

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_signed = 1'b0;
        d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_rv", 32'({if_rvalid, d_rvalid}), 32'd0);
        chk("rst_mem", 32'({mem_read, mem_write, mem_inst}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdat", if_rdata | d_rdata, 32'd0);
        rst = 1'b1;

        // Contention from reset: fetch, data, fetch, data.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                if_req = 1'b1; if_addr = 8'h08;
                d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 8'h00;
            end else begin
                if_req = 1'b0; d_req = 1'b0;
            end
            #1;
            if (c < 4) begin
                chk($sformatf("rr_ig%0d", c), 32'(if_gnt), 32'(c % 2 == 0));
                chk($sformatf("rr_dg%0d", c), 32'(d_gnt), 32'(c % 2 == 1));
            end
            if (c >= 2) begin
                chk($sformatf("rr_irv%0d", c), 32'(if_rvalid), 32'(c % 2 == 0));
                chk($sformatf("rr_drv%0d", c), 32'(d_rvalid), 32'(c % 2 == 1));
                if (c % 2 == 0) chk($sformatf("rr_ird%0d", c), if_rdata, 32'h00100093);
                else chk($sformatf("rr_drd%0d", c), d_rdata, 32'h80345678);
            end
        end

        for (int i = 0; i < 11; i++) run_vec(vt[i], i);

        // Store then load of the same word on consecutive grants.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 8'h0C;
        d_wdata = 32'hDEADBEEF;
        #1 chk("sl_g0", 32'(d_gnt), 32'd1);
        @(negedge clk);
        d_we = 1'b0; d_wdata = 32'h0;
        #1 chk("sl_g1", 32'(d_gnt), 32'd1);
        @(negedge clk);
        d_req = 1'b0;
        chk("sl_rv0", 32'({d_rvalid, d_err}), 32'b10);
        chk("sl_rd0", d_rdata, 32'h0);
        @(negedge clk);
        chk("sl_rv1", 32'({d_rvalid, d_err}), 32'b10);
        chk("sl_rd1", d_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("sl_rvq", 32'(d_rvalid), 32'd0);

        // Reset while a store is in the access stage.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 8'h20;
        d_wdata = 32'h11223344;
        #1 chk("rs_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        chk("rs_mwr1", 32'(mem_write), 32'd1);
        rst = 1'b0;
        #1;
        chk("rs_mwr0", 32'(mem_write), 32'd0);
        chk("rs_mrd0", 32'(mem_read), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rs_rvr", 32'(d_rvalid), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rs_rv%0d", c), 32'({d_rvalid, if_rvalid}), 32'd0);
        end
        chk("rs_mem", {data_mem[8'h23], data_mem[8'h22], data_mem[8'h21], data_mem[8'h20]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
